// File: rtl/countdown_ctl.sv
// countdown_ctl: start/pause/clear/timeout sequencer for a 2-digit BCD
// countdown display. All outputs are registered from the next-state values,
// so every change is visible one clk after the causing input.
// Optional feature: define CNTDN_AUTO_RELOAD_EN to make DONE restart the
// countdown by itself after RELOAD_TICKS ticks.
module countdown_ctl #(
    parameter int INIT_TENS    = 3,
    parameter int INIT_ONES    = 0,
    parameter int RELOAD_TICKS = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        tick,
    input  logic        btn_ss,
    input  logic        btn_clr,
    output logic [3:0]  digit1,
    output logic [3:0]  digit0,
    output logic [15:0] led,
    output logic        count_en,
    output logic [1:0]  state
);

    typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, PAUSE = 2'd2, DONE = 2'd3} state_e;

    localparam logic [3:0] PRE_T = 4'(INIT_TENS);
    localparam logic [3:0] PRE_O = 4'(INIT_ONES);

    if (INIT_TENS < 0 || INIT_TENS > 9 || INIT_ONES < 0 || INIT_ONES > 9 ||
        RELOAD_TICKS < 1 || RELOAD_TICKS > 15) begin : g_bad_param
        $error("countdown_ctl: parameter out of range");
    end

    state_e      state_q, state_d;
    logic [3:0]  tens_q, tens_d, ones_q, ones_d;
    logic        blink_q, blink_d;
    logic [3:0]  digit1_q, digit0_q;
    logic [15:0] led_q;
    logic        count_en_q;
    logic        at_zero, at_one;

`ifdef CNTDN_AUTO_RELOAD_EN
    logic [3:0]  tcnt_q, tcnt_d;
`endif

    assign at_zero = (tens_q == 4'd0) && (ones_q == 4'd0);
    assign at_one  = (tens_q == 4'd0) && (ones_q == 4'd1);

    // Next-state logic: clear beats start/stop beats tick, except that a tick
    // in RUN is still applied when start/stop pauses on the same edge.
    always_comb begin
        state_d = state_q;
        tens_d  = tens_q;
        ones_d  = ones_q;
        blink_d = blink_q;
`ifdef CNTDN_AUTO_RELOAD_EN
        tcnt_d  = tcnt_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (btn_clr) begin
                    tens_d = PRE_T;
                    ones_d = PRE_O;
                end else if (btn_ss) begin
                    state_d = at_zero ? DONE : RUN;
                end
            end
            RUN: begin
                if (btn_clr) begin
                    state_d = IDLE;
                    tens_d  = PRE_T;
                    ones_d  = PRE_O;
                end else begin
                    if (tick) begin
                        // Never wrap below 00; reaching 00 ends the run.
                        if (!at_zero) begin
                            if (ones_q == 4'd0) begin
                                ones_d = 4'd9;
                                tens_d = tens_q - 4'd1;
                            end else begin
                                ones_d = ones_q - 4'd1;
                            end
                        end
                        if (at_zero || at_one) state_d = DONE;
                    end
                    if (btn_ss) state_d = PAUSE;
                end
            end
            PAUSE: begin
                if (btn_clr) begin
                    state_d = IDLE;
                    tens_d  = PRE_T;
                    ones_d  = PRE_O;
                end else if (btn_ss) begin
                    state_d = RUN;
                end
            end
            DONE: begin
                if (btn_clr) begin
                    state_d = IDLE;
                    tens_d  = PRE_T;
                    ones_d  = PRE_O;
                    blink_d = 1'b0;
`ifdef CNTDN_AUTO_RELOAD_EN
                    tcnt_d  = 4'd0;
                end else if (tcnt_q == 4'(RELOAD_TICKS)) begin
                    state_d = RUN;
                    tens_d  = PRE_T;
                    ones_d  = PRE_O;
                    blink_d = 1'b0;
                    tcnt_d  = 4'd0;
                end else if (tick) begin
                    blink_d = ~blink_q;
                    tcnt_d  = tcnt_q + 4'd1;
                end
`else
                end else if (tick) begin
                    blink_d = ~blink_q;
                end
`endif
            end
        endcase
    end

    // State, value and registered outputs, all derived from next-state values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            tens_q     <= PRE_T;
            ones_q     <= PRE_O;
            blink_q    <= 1'b0;
            digit1_q   <= PRE_T;
            digit0_q   <= PRE_O;
            led_q      <= 16'h0000;
            count_en_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            tens_q     <= tens_d;
            ones_q     <= ones_d;
            blink_q    <= blink_d;
            digit1_q   <= (state_d == DONE && blink_d) ? 4'hF : tens_d;
            digit0_q   <= (state_d == DONE && blink_d) ? 4'hF : ones_d;
            led_q      <= (state_d == DONE) ? {16{blink_d}}
                        : {state_d == RUN, state_d == PAUSE, 14'd0};
            count_en_q <= (state_d == RUN);
        end
    end

`ifdef CNTDN_AUTO_RELOAD_EN
    // Ticks spent in DONE, counted toward the automatic restart.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) tcnt_q <= 4'd0;
        else        tcnt_q <= tcnt_d;
    end
`endif

    assign state    = state_q;
    assign digit1   = digit1_q;
    assign digit0   = digit0_q;
    assign led      = led_q;
    assign count_en = count_en_q;

endmodule

// File: tb/tb_countdown_ctl.sv
// Self-checking bench for countdown_ctl: directed scenarios plus a random
// run, compared every cycle against a value-level reference model.
module tb_countdown_ctl;

    localparam int PRESET = 30;
    localparam int RT     = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        tick = 1'b0, btn_ss = 1'b0, btn_clr = 1'b0;
    logic [3:0]  digit1, digit0;
    logic [15:0] led;
    logic        count_en;
    logic [1:0]  state;

    // Second instance with a 00 preset
    logic        z_ss = 1'b0;
    logic [3:0]  z_d1, z_d0;
    logic [15:0] z_led;
    logic        z_en;
    logic [1:0]  z_st;

    int errs = 0, checks = 0;

    // Reference model: integer count value plus mode/blink/tick-count
    int m_val = PRESET, m_st = 0, m_blink = 0, m_cnt = 0;

    countdown_ctl #(.INIT_TENS(3), .INIT_ONES(0), .RELOAD_TICKS(RT)) dut (
        .clk(clk), .rst_n(rst_n), .tick(tick), .btn_ss(btn_ss), .btn_clr(btn_clr),
        .digit1(digit1), .digit0(digit0), .led(led), .count_en(count_en), .state(state));

    countdown_ctl #(.INIT_TENS(0), .INIT_ONES(0), .RELOAD_TICKS(RT)) dut_z (
        .clk(clk), .rst_n(rst_n), .tick(1'b0), .btn_ss(z_ss), .btn_clr(1'b0),
        .digit1(z_d1), .digit0(z_d0), .led(z_led), .count_en(z_en), .state(z_st));

    always #5 clk = ~clk;

`ifdef CNTDN_AUTO_RELOAD_EN
    localparam bit AUTO = 1'b1;
`else
    localparam bit AUTO = 1'b0;
`endif

    function automatic void model_reset();
        m_val = PRESET; m_st = 0; m_blink = 0; m_cnt = 0;
    endfunction

    function automatic void model_edge(bit tk, bit ss, bit clr);
        case (m_st)
            0: if (clr) m_val = PRESET;
               else if (ss) m_st = (m_val == 0) ? 3 : 1;
            1: if (clr) begin m_st = 0; m_val = PRESET; end
               else begin
                   if (tk) begin
                       if (m_val > 0) m_val--;
                       if (m_val == 0) m_st = 3;
                   end
                   if (ss) m_st = 2;
               end
            2: if (clr) begin m_st = 0; m_val = PRESET; end
               else if (ss) m_st = 1;
            default: if (clr) begin m_st = 0; m_val = PRESET; m_blink = 0; m_cnt = 0; end
               else if (AUTO && m_cnt == RT) begin
                   m_st = 1; m_val = PRESET; m_blink = 0; m_cnt = 0;
               end else if (tk) begin
                   m_blink ^= 1;
                   if (AUTO) m_cnt++;
               end
        endcase
    endfunction

    function automatic logic [26:0] exp_vec();
        logic [3:0] d1, d0; logic [15:0] l;
        d1 = 4'(m_val / 10); d0 = 4'(m_val % 10);
        if (m_st == 3 && m_blink == 1) begin d1 = 4'hF; d0 = 4'hF; end
        l = (m_st == 3) ? (m_blink == 1 ? 16'hFFFF : 16'h0000)
          : (m_st == 1) ? 16'h8000 : (m_st == 2) ? 16'h4000 : 16'h0000;
        return {2'(m_st), d1, d0, l, (m_st == 1)};
    endfunction

    function automatic logic [26:0] got();
        return {state, digit1, digit0, led, count_en};
    endfunction

    // One clock edge with the given pulses; returns #1 after the edge.
    task automatic step(bit tk, bit ss, bit clr);
        tick = tk; btn_ss = ss; btn_clr = clr;
        @(posedge clk);
        model_edge(tk, ss, clr);
        #1;
        tick = 1'b0; btn_ss = 1'b0; btn_clr = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #12;
        model_reset();
        if (got() !== {2'd0, 4'd3, 4'd0, 16'h0000, 1'b0}) begin
            errs++; $display("FAIL reset_values got=%h exp=%h", got(), {2'd0, 4'd3, 4'd0, 16'h0000, 1'b0});
        end
        checks++;
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        step(0, 1, 0);
        if (state !== 2'd1 || count_en !== 1'b1) begin
            errs++; $display("FAIL start_run got st=%0d en=%0d exp st=1 en=1", state, count_en);
        end
        checks++;
        step(1, 0, 0);
        if ({digit1, digit0} !== 8'h29) begin
            errs++; $display("FAIL first_tick got=%h exp=29", {digit1, digit0});
        end
        checks++;
        step(1, 0, 0);
        if ({digit1, digit0} !== 8'h28 || got() !== exp_vec()) begin
            errs++; $display("FAIL second_tick got=%h exp=%h", got(), exp_vec());
        end
        checks++;
        step(0, 0, 1);
    endtask

    task automatic test_countdown();
        step(0, 1, 0);
        for (int i = 1; i <= 30; i++) begin
            step(1, 0, 0);
            if (got() !== exp_vec()) begin
                errs++; $display("FAIL countdown tick%0d got=%h exp=%h", i, got(), exp_vec());
            end
            checks++;
        end
        if (state !== 2'd3 || {digit1, digit0} !== 8'h00) begin
            errs++; $display("FAIL reach_done got st=%0d d=%h exp st=3 d=00", state, {digit1, digit0});
        end
        checks++;
        step(1, 0, 0);
        if ({digit1, digit0} !== 8'hFF || led !== 16'hFFFF) begin
            errs++; $display("FAIL blink_on got d=%h led=%h exp d=FF led=FFFF", {digit1, digit0}, led);
        end
        checks++;
        step(1, 0, 0);
        if ({digit1, digit0} !== 8'h00 || led !== 16'h0000) begin
            errs++; $display("FAIL blink_off got d=%h led=%h exp d=00 led=0000", {digit1, digit0}, led);
        end
        checks++;
        step(0, 1, 0);
        if (state !== 2'd3) begin
            errs++; $display("FAIL done_ignores_ss got st=%0d exp st=3", state);
        end
        checks++;
        step(0, 0, 1);
        if (got() !== {2'd0, 4'd3, 4'd0, 16'h0000, 1'b0}) begin
            errs++; $display("FAIL done_clear got=%h exp=%h", got(), {2'd0, 4'd3, 4'd0, 16'h0000, 1'b0});
        end
        checks++;
    endtask

    task automatic test_pause();
        step(0, 1, 0);
        for (int i = 0; i < 15; i++) step(1, 0, 0);
        step(1, 1, 0);
        if (state !== 2'd2 || {digit1, digit0} !== 8'h14 || led !== 16'h4000) begin
            errs++; $display("FAIL tick_and_pause got st=%0d d=%h led=%h exp st=2 d=14 led=4000", state, {digit1, digit0}, led);
        end
        checks++;
        for (int i = 0; i < 3; i++) step(1, 0, 0);
        if (got() !== exp_vec() || {digit1, digit0} !== 8'h14) begin
            errs++; $display("FAIL pause_frozen got=%h exp=%h", got(), exp_vec());
        end
        checks++;
        step(0, 1, 0);
        if (state !== 2'd1 || count_en !== 1'b1) begin
            errs++; $display("FAIL resume got st=%0d en=%0d exp st=1 en=1", state, count_en);
        end
        checks++;
        step(1, 0, 1);
        if (state !== 2'd0 || {digit1, digit0} !== 8'h30) begin
            errs++; $display("FAIL run_clear got st=%0d d=%h exp st=0 d=30", state, {digit1, digit0});
        end
        checks++;
    endtask

    task automatic test_clear_priority();
        step(0, 1, 0);
        step(1, 0, 0);
        step(0, 1, 0);
        step(0, 1, 1);
        if (state !== 2'd0 || {digit1, digit0} !== 8'h30 || count_en !== 1'b0) begin
            errs++; $display("FAIL clr_beats_ss got st=%0d d=%h exp st=0 d=30", state, {digit1, digit0});
        end
        checks++;
        if (z_st !== 2'd0 || {z_d1, z_d0} !== 8'h00) begin
            errs++; $display("FAIL zero_preset_idle got st=%0d d=%h exp st=0 d=00", z_st, {z_d1, z_d0});
        end
        checks++;
        z_ss = 1'b1;
        @(posedge clk); #1;
        z_ss = 1'b0;
        if (z_st !== 2'd3 || {z_d1, z_d0} !== 8'h00 || z_en !== 1'b0 || z_led !== 16'h0000) begin
            errs++; $display("FAIL zero_preset_done got st=%0d d=%h exp st=3 d=00", z_st, {z_d1, z_d0});
        end
        checks++;
    endtask

    task automatic test_async_reset();
        step(0, 1, 0);
        step(1, 0, 0);
        step(1, 0, 0);
        #2 rst_n = 1'b0;
        #1;
        if (got() !== {2'd0, 4'd3, 4'd0, 16'h0000, 1'b0}) begin
            errs++; $display("FAIL async_reset got=%h exp=%h", got(), {2'd0, 4'd3, 4'd0, 16'h0000, 1'b0});
        end
        checks++;
        model_reset();
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_done_reload();
        step(0, 1, 0);
        for (int i = 0; i < 30; i++) step(1, 0, 0);
        for (int i = 0; i < 12; i++) begin
            step((i < RT || !AUTO) ? 1'b1 : 1'b0, 0, 0);
            if (got() !== exp_vec()) begin
                errs++; $display("FAIL done_seq cyc%0d got=%h exp=%h", i, got(), exp_vec());
            end
            checks++;
        end
        if (AUTO) begin
            if (state !== 2'd1 || {digit1, digit0} !== 8'h30 || count_en !== 1'b1) begin
                errs++; $display("FAIL auto_reload got st=%0d d=%h en=%0d exp st=1 d=30 en=1", state, {digit1, digit0}, count_en);
            end
        end else begin
            if (state !== 2'd3) begin
                errs++; $display("FAIL done_holds got st=%0d exp st=3", state);
            end
        end
        checks++;
        step(0, 0, 1);
    endtask

    task automatic test_random();
        for (int i = 0; i < 600; i++) begin
            step($urandom_range(2) == 0, $urandom_range(9) == 0, $urandom_range(39) == 0);
            if (got() !== exp_vec()) begin
                errs++; $display("FAIL random cyc%0d got=%h exp=%h", i, got(), exp_vec());
            end
            checks++;
        end
    endtask

    initial begin
        test_reset();
        test_countdown();
        test_pause();
        test_clear_priority();
        test_async_reset();
        test_done_reload();
        test_random();
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
